commit_trace_buffer: RTL and testbench

//  Captures every instruction retired by the ROB commit stage into a FIFO of trace records.

---
 rtl/commit_trace_buffer_pkg.sv | 26 ++
 rtl/commit_trace_buffer_trace_fifo.sv | 46 ++++
 rtl/commit_trace_buffer.sv | 83 ++++++++
 tb/tb_commit_trace_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// commit_trace_buffer_pkg: shared trace record type, widths and opcode constants for trace consumers
package commit_trace_buffer_pkg;
  localparam int TRACE_DEPTH = 16;
  localparam int XLEN = 32;
  localparam int PHY_W = 6;
  localparam int SEQ_W = 32;
  localparam logic [6:0] OPC_LOAD = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6f;
  localparam logic [6:0] OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_OP = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic             we;
    logic [4:0]       rd_arch;
    logic [PHY_W-1:0] rd_phy;
    logic [XLEN-1:0]  wdata;
  } TRACE_REC_t;
endpackage

// File: rtl/commit_trace_buffer_trace_fifo.sv
// trace_fifo: generic DEPTH x WIDTH show-ahead FIFO with sync clear; head reads 0 when empty
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata = empty ? '0 : mem[rptr];
  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= (do_push & !do_pop) ? count + (AW+1)'(1) : (do_pop & !do_push) ? count - (AW+1)'(1) : count;
    end
  end
  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO of ROB commit trace records; COMMIT_TRACE_STALL_EN selects lossless stall mode over drop mode
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   commit_valid_i,
  output logic                   commit_ready_o,
  input  logic [XLEN-1:0]        commit_pc_i,
  input  logic [XLEN-1:0]        commit_instr_i,
  input  logic                   commit_we_i,
  input  logic [4:0]             commit_rd_arch_i,
  input  logic [PHY_W-1:0]       commit_rd_phy_i,
  input  logic [XLEN-1:0]        commit_wdata_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output TRACE_REC_t             trace_rec_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic                   overflow_o
);
  logic full, empty, alive, pop, accept, seq_adv;
  logic [SEQ_W-1:0] seq;
  TRACE_REC_t rec;
  assign pop = trace_valid_o & trace_ready_i;
  assign trace_valid_o = !empty;
  assign commit_ready_o = alive & !full;
`ifdef COMMIT_TRACE_STALL_EN
  assign accept = commit_valid_i & commit_ready_o;
  assign seq_adv = accept;
  assign drop_cnt_o = '0;
  assign overflow_o = 1'b0;
`else
  logic drop;
  assign accept = commit_valid_i & (!full | pop);
  assign drop = commit_valid_i & !accept;
  assign seq_adv = commit_valid_i;
  // saturating drop counter and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (drop) begin
      drop_cnt_o <= &drop_cnt_o ? drop_cnt_o : drop_cnt_o + 1'b1;
      overflow_o <= 1'b1;
    end
  end
`endif
  // alive holds commit_ready_o low until the first clock after reset release; seq numbers every counted commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
      seq <= '0;
    end else begin
      alive <= 1'b1;
      seq <= clear_i ? '0 : seq_adv ? seq + 1'b1 : seq;
    end
  end
  // record assembly; writes to x0 are never reported as writes
  always_comb begin
    rec = '{seq: seq, pc: commit_pc_i, instr: commit_instr_i, we: commit_we_i & (|commit_rd_arch_i),
            rd_arch: commit_rd_arch_i, rd_phy: commit_rd_phy_i, wdata: commit_wdata_i};
  end
  trace_fifo #(.DEPTH(DEPTH), .WIDTH($bits(TRACE_REC_t))) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear_i),
    .push(accept & !clear_i),
    .pop(pop),
    .wdata(rec),
    .rdata(trace_rec_o),
    .full(full),
    .empty(empty),
    .count(count_o)
  );
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: scoreboard bench for commit_trace_buffer (drop mode, or stall mode with COMMIT_TRACE_STALL_EN)
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 0, clear = 0, commit_valid = 0, commit_we = 0, trace_ready = 0;
  logic commit_ready, trace_valid, overflow;
  logic [31:0] pc = 0, instr = 0, wdata = 0;
  logic [4:0] rd = 0;
  logic [5:0] phy = 0;
  logic [4:0] count;
  logic [15:0] drop_cnt;
  TRACE_REC_t rec;
  TRACE_REC_t exp_q[$];
  logic [31:0] m_seq = 0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .commit_valid_i(commit_valid), .commit_ready_o(commit_ready),
    .commit_pc_i(pc), .commit_instr_i(instr), .commit_we_i(commit_we),
    .commit_rd_arch_i(rd), .commit_rd_phy_i(phy), .commit_wdata_i(wdata),
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready), .trace_rec_o(rec),
    .count_o(count), .drop_cnt_o(drop_cnt), .overflow_o(overflow)
  );

  // scoreboard: inputs are stable at negedge; compare head on pop, push predicted records on accept
  always @(negedge clk) begin
    bit pop_m, full_m, acc;
    if (!rst_n) begin
      exp_q.delete();
      m_seq = 0;
    end else begin
      n_cmp++;
      if (trace_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL sb_valid: got %b want %b", trace_valid, exp_q.size() != 0);
      end
      if (clear) begin
        exp_q.delete();
        m_seq = 0;
      end else begin
        full_m = exp_q.size() == DEPTH;
        pop_m = trace_ready && exp_q.size() != 0;
        if (pop_m) begin
          n_cmp++;
          if (rec !== exp_q[0]) begin
            n_err++;
            $display("FAIL sb_rec: got seq=%0d pc=%h we=%b rd=%0d wd=%h want seq=%0d pc=%h we=%b rd=%0d wd=%h",
                     rec.seq, rec.pc, rec.we, rec.rd_arch, rec.wdata,
                     exp_q[0].seq, exp_q[0].pc, exp_q[0].we, exp_q[0].rd_arch, exp_q[0].wdata);
          end
          void'(exp_q.pop_front());
        end
`ifdef COMMIT_TRACE_STALL_EN
        acc = commit_valid && !full_m;
`else
        acc = commit_valid && (!full_m || pop_m);
`endif
        if (acc)
          exp_q.push_back('{seq: m_seq, pc: pc, instr: instr, we: commit_we && rd != 0,
                            rd_arch: rd, rd_phy: phy, wdata: wdata});
`ifdef COMMIT_TRACE_STALL_EN
        if (acc) m_seq = m_seq + 1;
`else
        if (commit_valid) m_seq = m_seq + 1;
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit_op(input logic [31:0] p, input logic we, input logic [4:0] r, input logic [31:0] d);
    commit_valid = 1; pc = p; instr = 32'h0000_0013 ^ p; commit_we = we; rd = r; phy = {1'b1, r}; wdata = d;
    @(posedge clk);
    #1;
    commit_valid = 0;
  endtask

  task automatic do_clear;
    clear = 1;
    idle(1);
    clear = 0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({commit_ready, trace_valid, count, drop_cnt, overflow} !== '0 || rec !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b v=%b cnt=%0d drop=%0d ovf=%b rec=%h want all 0",
               commit_ready, trace_valid, count, drop_cnt, overflow, rec);
    end
    #13 rst_n = 1;
    n_cmp++;
    if (commit_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_pre: got %b want 0", commit_ready);
    end
    idle(1);
    n_cmp++;
    if (commit_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_post: got %b want 1", commit_ready);
    end
  endtask

  task automatic test_in_order;
    trace_ready = 1;
    commit_op(32'h0, 1, 5'd1, 32'h11);
    n_cmp++;
    if (trace_valid !== 1'b1 || rec.seq !== 32'd0 || rec.pc !== 32'h0) begin
      n_err++;
      $display("FAIL order_first: got v=%b seq=%0d pc=%h want v=1 seq=0 pc=0", trace_valid, rec.seq, rec.pc);
    end
    commit_op(32'h4, 1, 5'd2, 32'h22);
    commit_op(32'h8, 0, 5'd3, 32'h33);
    idle(2);
    n_cmp++;
    if (count !== 5'd0) begin
      n_err++;
      $display("FAIL order_count: got %0d want 0", count);
    end
    trace_ready = 0;
  endtask

`ifndef COMMIT_TRACE_STALL_EN
  task automatic test_overflow;
    do_clear();
    trace_ready = 0;
    for (int i = 0; i < 20; i++) commit_op(32'(i * 4), 1, 5'(i + 1), 32'(i * 3));
    n_cmp++;
    if (count !== 5'd16 || drop_cnt !== 16'd4 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_state: got cnt=%0d drop=%0d ovf=%b want cnt=16 drop=4 ovf=1", count, drop_cnt, overflow);
    end
    n_cmp++;
    if (commit_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_ready: got %b want 0", commit_ready);
    end
    trace_ready = 1;
    idle(16);
    trace_ready = 0;
    commit_op(32'h200, 1, 5'd7, 32'h77);
    n_cmp++;
    if (rec.seq !== 32'd20) begin
      n_err++;
      $display("FAIL ovf_next_seq: got %0d want 20", rec.seq);
    end
    trace_ready = 1;
    idle(1);
    trace_ready = 0;
  endtask

  task automatic test_full_pop;
    trace_ready = 0;
    for (int i = 0; i < 16; i++) commit_op(32'h1000 + 32'(i * 4), 1, 5'd9, 32'(i));
    n_cmp++;
    if (count !== 5'd16) begin
      n_err++;
      $display("FAIL fullpop_fill: got %0d want 16", count);
    end
    trace_ready = 1;
    commit_op(32'h2000, 1, 5'd10, 32'hABC);
    n_cmp++;
    if (count !== 5'd16 || drop_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL fullpop_accept: got cnt=%0d drop=%0d want cnt=16 drop=4", count, drop_cnt);
    end
    idle(16);
    trace_ready = 0;
    n_cmp++;
    if (count !== 5'd0) begin
      n_err++;
      $display("FAIL fullpop_drain: got %0d want 0", count);
    end
  endtask
`else
  task automatic test_stall;
    do_clear();
    trace_ready = 0;
    for (int i = 0; i < 16; i++) commit_op(32'(i * 4), 1, 5'd4, 32'(i));
    n_cmp++;
    if (commit_ready !== 1'b0 || count !== 5'd16) begin
      n_err++;
      $display("FAIL stall_full: got rdy=%b cnt=%0d want rdy=0 cnt=16", commit_ready, count);
    end
    commit_op(32'h40, 1, 5'd4, 32'h99);
    n_cmp++;
    if (count !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL stall_17th: got cnt=%0d drop=%0d ovf=%b want 16 0 0", count, drop_cnt, overflow);
    end
    trace_ready = 1;
    idle(16);
    trace_ready = 0;
    commit_op(32'h44, 1, 5'd4, 32'h98);
    n_cmp++;
    if (rec.seq !== 32'd16) begin
      n_err++;
      $display("FAIL stall_seq: got %0d want 16", rec.seq);
    end
    trace_ready = 1;
    idle(1);
    trace_ready = 0;
  endtask
`endif

  task automatic test_x0;
    trace_ready = 0;
    commit_op(32'h100, 1, 5'd0, 32'hDEAD);
    n_cmp++;
    if (rec.we !== 1'b0 || rec.rd_arch !== 5'd0 || rec.wdata !== 32'hDEAD) begin
      n_err++;
      $display("FAIL x0_mask: got we=%b rd=%0d wd=%h want we=0 rd=0 wd=dead", rec.we, rec.rd_arch, rec.wdata);
    end
    commit_op(32'h104, 1, 5'd5, 32'hBEEF);
    trace_ready = 1;
    idle(1);
    trace_ready = 0;
    n_cmp++;
    if (rec.we !== 1'b1 || rec.rd_arch !== 5'd5) begin
      n_err++;
      $display("FAIL x0_normal: got we=%b rd=%0d want we=1 rd=5", rec.we, rec.rd_arch);
    end
    trace_ready = 1;
    idle(1);
    trace_ready = 0;
  endtask

  task automatic test_clear;
    trace_ready = 0;
    for (int i = 0; i < 5; i++) commit_op(32'h300 + 32'(i * 4), 0, 5'd2, 32'(i));
    n_cmp++;
    if (count !== 5'd5) begin
      n_err++;
      $display("FAIL clear_fill: got %0d want 5", count);
    end
    clear = 1;
    commit_op(32'h400, 1, 5'd3, 32'h55);
    clear = 0;
    n_cmp++;
    if (trace_valid !== 1'b0 || count !== 5'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_state: got v=%b cnt=%0d drop=%0d ovf=%b want all 0", trace_valid, count, drop_cnt, overflow);
    end
    commit_op(32'h404, 1, 5'd3, 32'h56);
    n_cmp++;
    if (rec.seq !== 32'd0 || count !== 5'd1) begin
      n_err++;
      $display("FAIL clear_seq: got seq=%0d cnt=%0d want seq=0 cnt=1", rec.seq, count);
    end
    trace_ready = 1;
    idle(1);
    trace_ready = 0;
  endtask

  task automatic test_async_reset;
    trace_ready = 0;
    for (int i = 0; i < 3; i++) commit_op(32'h500 + 32'(i * 4), 1, 5'd6, 32'(i));
    commit_valid = 1;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({commit_ready, trace_valid, count, drop_cnt, overflow} !== '0 || rec !== '0) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%b v=%b cnt=%0d drop=%0d ovf=%b rec=%h want all 0",
               commit_ready, trace_valid, count, drop_cnt, overflow, rec);
    end
    commit_valid = 0;
    @(negedge clk);
    #1 rst_n = 1;
    idle(1);
    commit_op(32'h600, 1, 5'd8, 32'h66);
    n_cmp++;
    if (rec.seq !== 32'd0 || count !== 5'd1) begin
      n_err++;
      $display("FAIL async_after: got seq=%0d cnt=%0d want seq=0 cnt=1", rec.seq, count);
    end
    trace_ready = 1;
    idle(2);
    trace_ready = 0;
  endtask

  initial begin
    test_reset();
    test_in_order();
`ifndef COMMIT_TRACE_STALL_EN
    test_overflow();
    test_full_pop();
`else
    test_stall();
`endif
    test_x0();
    test_clear();
    test_async_reset();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
